// File: rtl/req_encoder8_3.sv
// Sequential 8-to-3 request encoder. It latches request pulses into a pending vector
// and presents one pending index at a time under a valid/ack handshake.
module req_encoder8_3 #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ack,
    input  logic       clr_ovr,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overrun
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_e;

    state_e     state_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic [2:0] last_q, last_d;
    state_e     state_d;

    logic [7:0] clr;
    logic [7:0] rest;
    logic       accept;

    // Winner of search vector s. In round-robin mode the scan starts just after
    // index last and wraps; otherwise the highest set bit wins.
    function automatic logic [2:0] pick(input logic [7:0] s, input logic [2:0] last);
        logic [2:0] res;
        logic [2:0] idx;
        logic       found;
        res   = 3'd0;
        found = 1'b0;
        if (ROUND_ROBIN) begin
            for (int off = 1; off <= 8; off++) begin
                idx = last + 3'(off);
                if (!found && s[idx]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (s[i]) res = 3'(i);
            end
        end
        return res;
    endfunction

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        accept    = valid_q && ack;
        clr       = accept ? (8'h01 << code_q) : 8'h00;
        rest      = pending_q & ~clr;
        pending_d = rest | req;

        // Re-requesting a line in its own retire cycle is a fresh request, not an overrun.
        if (|(req & rest)) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (pending_q != 8'h00) begin
                    code_d  = pick(pending_q, last_q);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (accept) begin
                    last_d = code_q;
                    // Requests arriving in this cycle are not in rest; they wait a cycle.
                    if (rest != 8'h00) begin
                        code_d = pick(rest, code_q);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            last_q    <= 3'd7;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            last_q    <= last_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_req_encoder8_3.sv
// Directed self-checking bench for req_encoder8_3, covering both the fixed-priority
// and the round-robin configuration.
module tb_req_encoder8_3;

    logic       clk;
    logic       rst_n;

    logic [7:0] req_fp, req_rr;
    logic       ack_fp, ack_rr;
    logic       clr_ovr_fp, clr_ovr_rr;
    logic [2:0] code_fp, code_rr;
    logic       valid_fp, valid_rr;
    logic [7:0] pending_fp, pending_rr;
    logic       overrun_fp, overrun_rr;

    int n_cmp = 0;
    int n_err = 0;

    req_encoder8_3 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_fp),
        .ack     (ack_fp),
        .clr_ovr (clr_ovr_fp),
        .code    (code_fp),
        .valid   (valid_fp),
        .pending (pending_fp),
        .overrun (overrun_fp)
    );

    req_encoder8_3 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_rr),
        .ack     (ack_rr),
        .clr_ovr (clr_ovr_rr),
        .code    (code_rr),
        .valid   (valid_rr),
        .pending (pending_rr),
        .overrun (overrun_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_fp     = 8'h00;
        ack_fp     = 1'b0;
        clr_ovr_fp = 1'b0;
        req_rr     = 8'h00;
        ack_rr     = 1'b0;
        clr_ovr_rr = 1'b0;
        #12;
        rst_n = 1'b1;

        check("rst_pending", 32'(pending_fp), 32'h00);
        check("rst_valid",   32'(valid_fp),   32'd0);
        check("rst_code",    32'(code_fp),    32'd0);
        check("rst_overrun", 32'(overrun_fp), 32'd0);

        // Fixed priority: 7, 5, 2 back-to-back with ack held high.
        ack_fp = 1'b1;
        req_fp = 8'b1010_0100;
        tick();
        req_fp = 8'h00;
        check("fp_pend_e1",  32'(pending_fp), 32'hA4);
        check("fp_valid_e1", 32'(valid_fp),   32'd0);
        tick();
        check("fp_valid_e2", 32'(valid_fp), 32'd1);
        check("fp_code_e2",  32'(code_fp),  32'd7);
        tick();
        check("fp_code_e3",  32'(code_fp),    32'd5);
        check("fp_pend_e3",  32'(pending_fp), 32'h24);
        tick();
        check("fp_code_e4",  32'(code_fp),  32'd2);
        check("fp_valid_e4", 32'(valid_fp), 32'd1);
        tick();
        check("fp_valid_e5", 32'(valid_fp),   32'd0);
        check("fp_pend_e5",  32'(pending_fp), 32'h00);
        ack_fp = 1'b0;

        // Hold without ack.
        req_fp = 8'h10;
        tick();
        req_fp = 8'h00;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_code",  32'(code_fp),  32'd4);
            check("hold_valid", 32'(valid_fp), 32'd1);
            tick();
        end
        ack_fp = 1'b1;
        tick();
        ack_fp = 1'b0;
        check("hold_done_valid", 32'(valid_fp),   32'd0);
        check("hold_done_pend",  32'(pending_fp), 32'h00);

        // Overrun: same line twice without an ack.
        req_fp = 8'h02;
        tick();
        tick();
        req_fp = 8'h00;
        check("ovr_set",   32'(overrun_fp), 32'd1);
        check("ovr_pend",  32'(pending_fp), 32'h02);
        check("ovr_code",  32'(code_fp),    32'd1);
        clr_ovr_fp = 1'b1;
        tick();
        clr_ovr_fp = 1'b0;
        check("ovr_clear", 32'(overrun_fp), 32'd0);
        ack_fp = 1'b1;
        tick();
        ack_fp = 1'b0;
        check("ovr_drain_valid", 32'(valid_fp),   32'd0);
        check("ovr_drain_pend",  32'(pending_fp), 32'h00);

        // Coincident clear and request on line 3.
        req_fp = 8'h08;
        tick();
        req_fp = 8'h00;
        tick();
        check("coin_code0",  32'(code_fp),    32'd3);
        check("coin_pend0",  32'(pending_fp), 32'h08);
        ack_fp = 1'b1;
        req_fp = 8'h08;
        tick();
        ack_fp = 1'b0;
        req_fp = 8'h00;
        check("coin_pend1",  32'(pending_fp), 32'h08);
        check("coin_ovr1",   32'(overrun_fp), 32'd0);
        check("coin_valid1", 32'(valid_fp),   32'd0);
        tick();
        check("coin_valid2", 32'(valid_fp), 32'd1);
        check("coin_code2",  32'(code_fp),  32'd3);
        ack_fp = 1'b1;
        tick();
        ack_fp = 1'b0;
        check("coin_done", 32'(valid_fp), 32'd0);

        // Asynchronous reset in the middle of a presentation.
        req_fp = 8'h0F;
        tick();
        tick();
        req_fp = 8'h00;
        check("mid_pend",  32'(pending_fp), 32'h0F);
        check("mid_valid", 32'(valid_fp),   32'd1);
        check("mid_code",  32'(code_fp),    32'd3);
        check("mid_ovr",   32'(overrun_fp), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pend",  32'(pending_fp), 32'h00);
        check("async_valid", 32'(valid_fp),   32'd0);
        check("async_code",  32'(code_fp),    32'd0);
        check("async_ovr",   32'(overrun_fp), 32'd0);
        #1;
        rst_n = 1'b1;

        // Round-robin: lines 0 and 7 requested every cycle alternate.
        req_rr = 8'h81;
        ack_rr = 1'b1;
        tick();
        check("rr_pend_e1",  32'(pending_rr), 32'h81);
        check("rr_valid_e1", 32'(valid_rr),   32'd0);
        tick();
        check("rr_valid_e2", 32'(valid_rr), 32'd1);
        check("rr_code_e2",  32'(code_rr),  32'd0);
        tick();
        check("rr_code_e3",  32'(code_rr),  32'd7);
        tick();
        check("rr_code_e4",  32'(code_rr),  32'd0);
        tick();
        check("rr_code_e5",  32'(code_rr),  32'd7);
        check("rr_valid_e5", 32'(valid_rr), 32'd1);
        req_rr = 8'h00;
        ack_rr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
